// File: rtl/uart_tx_engine.sv
// UART transmit engine with an integrated baud timer and a valid/ready payload port.
// Supports 5..MAX_DATA_WIDTH data bits, bit order, parity, stop length and break.
module uart_tx_engine #(
    parameter int unsigned MAX_DATA_WIDTH = 9,
    parameter int unsigned DIV_WIDTH      = 16,
    parameter int unsigned LEN_W          = $clog2(MAX_DATA_WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIV_WIDTH-1:0]      baud_div,
    input  logic [MAX_DATA_WIDTH-1:0] data_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [LEN_W-1:0]          data_bits,
    input  logic [2:0]                parity_mode,
    input  logic [1:0]                stop_mode,
    input  logic                      msb_first,
    input  logic                      break_req,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CNT_W    = $clog2(MAX_DATA_WIDTH);
    localparam int unsigned TMR_W    = DIV_WIDTH + 1;
    localparam int unsigned MIN_BITS = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_GUARD
    } state_e;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [MAX_DATA_WIDTH-1:0] data_q;
    logic [LEN_W-1:0]          nbits_q;
    logic [2:0]                pmode_q;
    logic [1:0]                smode_q;
    logic                      msb_q;
    logic [DIV_WIDTH-1:0]      div_q;

    logic                      cfg_load;
    logic                      brk_load;
    logic                      accept;
    logic                      tick;
    logic                      last_bit;
    logic                      par_en;
    logic                      par_bit;
    logic                      ones_odd;
    logic [DIV_WIDTH-1:0]      div_in_eff;
    logic [LEN_W-1:0]          nbits_in;
    logic [TMR_W-1:0]          start_tmr;
    logic [TMR_W-1:0]          bit_tmr;
    logic [TMR_W-1:0]          stop_tmr;
    logic [MAX_DATA_WIDTH-1:0] data_mask;
    logic [MAX_DATA_WIDTH-1:0] data_sh;
    logic [LEN_W-1:0]          bit_idx;

    // Incoming configuration, normalised before it is latched.
    assign div_in_eff = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    assign nbits_in   = (data_bits < LEN_W'(MIN_BITS))       ? LEN_W'(MIN_BITS) :
                        (data_bits > LEN_W'(MAX_DATA_WIDTH)) ? LEN_W'(MAX_DATA_WIDTH) :
                                                               data_bits;

    assign tick      = (timer_q == '0);
    assign start_tmr = TMR_W'(div_in_eff) - TMR_W'(1);
    assign bit_tmr   = TMR_W'(div_q) - TMR_W'(1);
    assign last_bit  = (LEN_W'(bit_cnt_q) == (nbits_q - LEN_W'(1)));
    assign par_en    = (pmode_q >= 3'b001) && (pmode_q <= 3'b100);

    always_comb begin
        case (smode_q)
            2'b00:   stop_tmr = TMR_W'(div_q) - TMR_W'(1);
            2'b01:   stop_tmr = TMR_W'(div_q) + TMR_W'(div_q >> 1) - TMR_W'(1);
            default: stop_tmr = {div_q, 1'b0} - TMR_W'(1);
        endcase
    end

    // Parity covers only the configured number of data bits.
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < int'(MAX_DATA_WIDTH); i++) begin
            data_mask[i] = (i < int'(nbits_q));
        end
        ones_odd = ^(data_q & data_mask);
        case (pmode_q)
            3'b001:  par_bit = ~ones_odd;
            3'b010:  par_bit = ones_odd;
            3'b011:  par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    assign data_ready = ~rst & ~break_req &
                        ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));
    assign accept     = data_valid & data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = tick ? '0 : timer_q - TMR_W'(1);
        bit_cnt_d = bit_cnt_q;
        cfg_load  = 1'b0;
        brk_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (break_req) begin
                    state_d  = S_BREAK;
                    brk_load = 1'b1;
                    timer_d  = '0;
                end else if (accept) begin
                    state_d  = S_START;
                    cfg_load = 1'b1;
                    timer_d  = start_tmr;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    timer_d   = bit_tmr;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (par_en) begin
                            state_d = S_PARITY;
                            timer_d = bit_tmr;
                        end else begin
                            state_d = S_STOP;
                            timer_d = stop_tmr;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        timer_d   = bit_tmr;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    timer_d = stop_tmr;
                end
            end
            S_STOP: begin
                // Final stop clock: a waiting payload chains straight into the next start bit.
                if (tick) begin
                    if (accept) begin
                        state_d  = S_START;
                        cfg_load = 1'b1;
                        timer_d  = start_tmr;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (!break_req) begin
                    state_d = S_GUARD;
                    timer_d = bit_tmr;
                end
            end
            S_GUARD: begin
                if (tick) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered line/status values derived from the upcoming state.
    always_comb begin
        tx_d    = 1'b1;
        bit_idx = msb_q ? (nbits_q - LEN_W'(1) - LEN_W'(bit_cnt_d)) : LEN_W'(bit_cnt_d);
        data_sh = data_q >> bit_idx;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_sh[0];
            S_PARITY: tx_d = par_bit;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (timer_d == '0);
    end

    // Frame configuration; a break captures only the divisor that times its guard interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            nbits_q <= LEN_W'(MIN_BITS);
            pmode_q <= '0;
            smode_q <= '0;
            msb_q   <= 1'b0;
            div_q   <= DIV_WIDTH'(1);
        end else if (cfg_load) begin
            data_q  <= data_in;
            nbits_q <= nbits_in;
            pmode_q <= parity_mode;
            smode_q <= stop_mode;
            msb_q   <= msb_first;
            div_q   <= div_in_eff;
        end else if (brk_load) begin
            div_q   <= div_in_eff;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a frame-level model predicts each tx waveform,
// a negedge monitor captures the line between busy and done and compares.
module tb_uart_tx_engine;

    localparam int MW = 9;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] baud_div;
    logic [MW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [LW-1:0] data_bits;
    logic [2:0]    parity_mode;
    logic [1:0]    stop_mode;
    logic          msb_first;
    logic          break_req;
    logic          tx;
    logic          busy;
    logic          done;

    uart_tx_engine #(.MAX_DATA_WIDTH(MW), .DIV_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_bits  (data_bits),
        .parity_mode(parity_mode),
        .stop_mode  (stop_mode),
        .msb_first  (msb_first),
        .break_req  (break_req),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           len;
        logic [511:0] wave;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   done_log[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Frame model: list of line bits, each held D clocks, followed by the stop interval.
    function automatic exp_t model(input logic [MW-1:0] d, input int nb_raw, input int pm,
                                   input int sm, input bit msb, input int div, input int acc);
        exp_t r;
        bit   q[$];
        int   dd;
        int   nb;
        int   ones;
        int   idx;
        int   stop;
        dd   = (div == 0) ? 1 : div;
        nb   = (nb_raw < 5) ? 5 : ((nb_raw > MW) ? MW : nb_raw);
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            idx = msb ? (nb - 1 - i) : i;
            q.push_back(d[idx]);
            ones += int'(d[idx]);
        end
        case (pm)
            1: q.push_back((ones % 2) == 0);
            2: q.push_back((ones % 2) == 1);
            3: q.push_back(1'b1);
            4: q.push_back(1'b0);
            default: ;
        endcase
        r.wave = '0;
        r.len  = 0;
        foreach (q[k]) begin
            for (int j = 0; j < dd; j++) begin
                r.wave[r.len] = q[k];
                r.len++;
            end
        end
        stop = (sm == 0) ? dd : ((sm == 1) ? dd + dd / 2 : 2 * dd);
        for (int j = 0; j < stop; j++) begin
            r.wave[r.len] = 1'b1;
            r.len++;
        end
        r.acc = acc;
        return r;
    endfunction

    // Monitor: captures tx while busy, checks a whole frame on each done pulse.
    logic [511:0] cap;
    int           ncap;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (rst || !busy) begin
            if (!rst && done) chk("done_outside_frame", 1, 0);
            cap  = '0;
            ncap = 0;
        end else begin
            if (ncap < 512) cap[ncap] = tx;
            ncap++;
            if (done) begin
                done_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_len", ncap, mon_e.len);
                    chk("frame_wave", longint'(cap == mon_e.wave), 1);
                    chk("frame_latency", cyc - mon_e.acc + 1, mon_e.len);
                    chk("done_ready", longint'(data_ready), longint'(!break_req));
                end
                cap  = '0;
                ncap = 0;
            end
        end
    end

    // Offer one payload and record its expected frame at the accepting edge.
    task automatic send(input logic [MW-1:0] d, input int nb, input int pm, input int sm,
                        input bit msb, input int div);
        int waited;
        bit got;
        waited      = 0;
        got         = 1'b0;
        data_in     = d;
        data_bits   = LW'(nb);
        parity_mode = 3'(pm);
        stop_mode   = 2'(sm);
        msb_first   = msb;
        baud_div    = DW'(div);
        data_valid  = 1'b1;
        while (!got && waited < 400) begin
            @(negedge clk);
            if (data_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            data_valid = 1'b0;
        end else begin
            exp_q.push_back(model(d, nb, pm, sm, msb, div, cyc + 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int w;
        rst         = 1'b1;
        data_valid  = 1'b0;
        break_req   = 1'b0;
        data_in     = '0;
        data_bits   = LW'(8);
        parity_mode = '0;
        stop_mode   = '0;
        msb_first   = 1'b0;
        baud_div    = DW'(4);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", data_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", data_ready, 1);

        // Test-plan frames.
        send(9'h0A5, 8, 0, 0, 1'b0, 4); data_valid = 1'b0; drain();
        send(9'h041, 7, 1, 0, 1'b1, 3); data_valid = 1'b0; drain();
        send(9'h1FF, 9, 2, 2, 1'b0, 2); data_valid = 1'b0; drain();
        send(9'h0C3, 8, 0, 1, 1'b0, 5); data_valid = 1'b0; drain();
        send(9'h03C, 8, 0, 1, 1'b0, 0); data_valid = 1'b0; drain();
        send(9'h1B6, 3, 2, 0, 1'b1, 1); data_valid = 1'b0; drain();
        send(9'h16D, 15, 1, 3, 1'b1, 2); data_valid = 1'b0; drain();

        // Back-to-back with valid held high.
        done_log.delete();
        send(9'h0A5, 8, 0, 0, 1'b0, 4);
        send(9'h05A, 8, 0, 0, 1'b0, 4);
        data_valid = 1'b0;
        drain();
        chk("b2b_done_count", done_log.size(), 2);
        if (done_log.size() == 2) chk("b2b_done_spacing", done_log[1] - done_log[0], 40);

        // Break: 20 clocks low, 4 guard clocks high, then ready.
        baud_div  = DW'(4);
        break_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 19) break_req = 1'b0;
            chk("break_tx", tx, 0);
            if (i < 19) chk("break_ready", data_ready, 0);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("guard_tx", tx, 1);
            chk("guard_ready", data_ready, 0);
        end
        @(posedge clk);
        #1;
        chk("post_guard_ready", data_ready, 1);
        chk("post_guard_busy", busy, 0);

        // Break requested mid-frame waits for the frame to finish.
        send(9'h0F0, 8, 0, 0, 1'b0, 2);
        data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        break_req = 1'b1;
        w = 0;
        while (!done && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("wait_done", done, 1);
        @(posedge clk);
        #1;
        chk("frame_end_tx", tx, 1);
        @(posedge clk);
        #1;
        chk("late_break_tx", tx, 0);
        break_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        drain();

        // Reset in the middle of the data phase.
        send(9'h0A5, 8, 0, 0, 1'b0, 4);
        data_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", data_ready, 0);
        exp_q.delete();
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("no_residual_frame", bad, 0);
        chk("ready_after_midrst", data_ready, 1);

        // Randomised frames; inputs are scrambled while frames are in flight.
        for (int n = 0; n < 40; n++) begin
            send(MW'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 0) begin
                data_valid  = 1'b0;
                data_in     = MW'($urandom);
                data_bits   = LW'($urandom);
                parity_mode = 3'($urandom);
                stop_mode   = 2'($urandom);
                msb_first   = 1'($urandom);
                baud_div    = DW'($urandom_range(0, 7));
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
